intersection_ctrl: RTL and testbench
====================================

Name: intersection_ctrl

Overview:
- Two-road intersection scheduler sequencing two car signal heads (road A, road B) and two pedestrian crossings.
- Arbitrates right-of-way between roads using:
  - car presence sensors;
  - latched pedestrian button requests;
  - min/max green timing.
- Adds all-red clearance between phases and a night flashing-yellow mode.
- Timing counts `tick` pulses from an upstream 1 Hz strobe, not raw clocks.

Parameters:
- GREEN_MIN, 10, minimum green duration in ticks.
- GREEN_MAX, 30, maximum green duration in ticks.
- YELLOW_T, 3, yellow duration in ticks.
- ALLRED_T, 2, all-red clearance duration in ticks.
- WALK_T, 8, pedestrian green duration in ticks.
- Legality: all values in 1..255, GREEN_MIN <= GREEN_MAX, WALK_T <= GREEN_MIN. Any other value is illegal.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; the single clock is clk, reset is synchronous and active-high
- tick  in  1  one-cycle timing strobe; all durations count these
- sens_a  in  1  car waiting on road A (level)
- sens_b  in  1  car waiting on road B (level)
- btn_ped_a  in  1  request to cross road A (pulse or level)
- btn_ped_b  in  1  request to cross road B
- night  in  1  night flashing-mode request (level)
- light_a  out  3  road A head; bit2 red, bit1 yellow, bit0 green
- light_b  out  3  road B head, same encoding
- ped_a  out  1  crossing over road A; 1 = red, 0 = green
- ped_b  out  1  crossing over road B; 1 = red, 0 = green
- req_pend  out  2  latched requests {ped_b, ped_a}
- phase  out  3  current state code, for debug

Behaviour:
- Moore machine. All outputs are decoded from registered state, timer, walk flag and flash bit, so they change on the edge that changes state.
- State codes:
  - 0 A_GREEN
  - 1 A_YELLOW
  - 2 ALLRED_AB (after A)
  - 3 B_GREEN
  - 4 B_YELLOW
  - 5 ALLRED_BA (after B)
  - 6 FLASH
- Reset (rst=1 at an edge): state = ALLRED_BA, timer = 0, both requests = 0, walk = 0, flash bit = 0. Outputs: light_a = light_b = 3'b100, ped_a = ped_b = 1, req_pend = 0. Reset takes effect from any state, including mid-phase.
- Timer: 8 bits, cleared on every state change, incremented only on cycles with tick=1. With tick=0, state, timer and flash bit hold.
- Fixed-length state of duration D: exits on the edge where tick=1 and timer == D-1. The state therefore lasts exactly D ticks.
- A_GREEN: light_a = 001, light_b = 100. Exits to A_YELLOW on a tick edge when either condition holds:
  - timer+1 >= GREEN_MIN and (sens_b or req_ped_a);
  - timer+1 == GREEN_MAX.
- B_GREEN: symmetric, using sens_a or req_ped_b.
- A_YELLOW and B_YELLOW: the yellow head shows 010, the other head shows 100. Duration YELLOW_T. A_YELLOW goes to ALLRED_AB; B_YELLOW goes to ALLRED_BA.
- ALLRED states: both heads 100. Duration ALLRED_T.
  - ALLRED_AB exits to B_GREEN.
  - ALLRED_BA exits to A_GREEN.
  - If night=1 at the exit edge, either ALLRED state goes to FLASH instead.
- Pedestrian requests:
  - req_ped_a is set by btn_ped_a. req_ped_b is set by btn_ped_b.
  - Requests are sticky until served.
- Serving ped_a on entry to B_GREEN:
  - Grant if req_ped_a or btn_ped_a is high at the entry edge; a press on that same edge is served, not lost.
  - On grant: walk = 1, req_ped_a is cleared, and ped_a = 0 for the first WALK_T ticks of B_GREEN, then 1.
- Serving ped_b: symmetric, on entry to A_GREEN.
- A button pressed while its own crossing is currently walking is ignored.
- A button pressed at any other time latches and is served at the next matching green.
- A pedestrian signal is never 0 outside the opposite road's green.
- Night mode:
  - night is sampled only at ALLRED exits. It is ignored during green and yellow.
  - FLASH: ped_a = ped_b = 1. Both heads show 010 when the flash bit is 1 and 000 when it is 0.
  - The flash bit is set to 1 on entry and toggles on each tick.
  - When night=0 at any FLASH edge, the next state is ALLRED_BA (full ALLRED_T, timer 0), then A_GREEN.
  - Pedestrian requests keep latching in FLASH and are served afterwards.
- Simultaneous sens_a and sens_b: alternation is fixed, so no starvation. Each road waits at most GREEN_MAX + YELLOW_T + ALLRED_T ticks.

Test Plan:
- Test 1, free-run with no demand: rst for 2 cycles, tick=1 every cycle, all inputs 0.
  - Required sequence: 100/100 for 2 cycles, then A 001 for 30 cycles, then A 010 for 3, then 100/100 for 2, then B 001 for 30.
- Test 2, sens_b=1 from reset: A_GREEN lasts exactly 10 cycles, then A_YELLOW.
- Test 3, pedestrian request served: btn_ped_a one-cycle pulse at A_GREEN timer=3.
  - req_pend = 01 on the next cycle.
  - A green ends after 10 ticks.
  - On B_GREEN entry: ped_a = 0 for 8 cycles, then 1, and req_pend = 00.
- Test 4, night mode: night=1 during A_GREEN.
  - A green, yellow and all-red complete normally, then FLASH.
  - Both heads alternate 010/000 each tick, starting with 010; peds = 1.
  - night=0 gives 2 cycles of 100/100, then A_GREEN.
- Test 5, reset mid-phase: rst=1 during B_YELLOW with req_pend=10.
  - Next cycle: both heads 100, peds 1, req_pend 00, phase = 5.
- Test 6, tick gating: tick=0 for 50 cycles mid A_GREEN holds outputs and phase. The remaining green resumes exactly when tick is restored.

Source files
------------

// File: rtl/intersection_ctrl.sv
// Two-road intersection scheduler: car heads, pedestrian crossings,
// all-red clearance and night flashing mode, timed in tick pulses.
module intersection_ctrl #(
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       sens_a,
  input  logic       sens_b,
  input  logic       btn_ped_a,
  input  logic       btn_ped_b,
  input  logic       night,
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic       ped_a,
  output logic       ped_b,
  output logic [1:0] req_pend,
  output logic [2:0] phase
);

  if (GREEN_MIN < 1 || GREEN_MIN > 255 ||
      GREEN_MAX < 1 || GREEN_MAX > 255 ||
      YELLOW_T  < 1 || YELLOW_T  > 255 ||
      ALLRED_T  < 1 || ALLRED_T  > 255 ||
      WALK_T    < 1 || WALK_T    > 255 ||
      GREEN_MIN > GREEN_MAX || WALK_T > GREEN_MIN) begin : g_illegal
    $error("intersection_ctrl: illegal timing parameters");
  end

  localparam logic [8:0] G_MIN = 9'(GREEN_MIN);
  localparam logic [8:0] G_MAX = 9'(GREEN_MAX);
  localparam logic [8:0] Y_T   = 9'(YELLOW_T);
  localparam logic [8:0] AR_T  = 9'(ALLRED_T);
  localparam logic [7:0] W_T   = 8'(WALK_T);

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5,
    FLASH     = 3'd6
  } state_t;

  state_t     state, state_nx;
  logic [7:0] timer, timer_nx;
  logic       req_a, req_a_nx;
  logic       req_b, req_b_nx;
  logic       walk, walk_nx;
  logic       flash, flash_nx;
  logic [8:0] t1;
  logic       walking_a, walking_b;

  assign t1 = {1'b0, timer} + 9'd1;
  assign walking_a = (state == B_GREEN) && walk && (timer < W_T);
  assign walking_b = (state == A_GREEN) && walk && (timer < W_T);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALLRED_BA;
      timer <= '0;
      req_a <= 1'b0;
      req_b <= 1'b0;
      walk  <= 1'b0;
      flash <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      req_a <= req_a_nx;
      req_b <= req_b_nx;
      walk  <= walk_nx;
      flash <= flash_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      A_GREEN:
        if (tick && ((t1 >= G_MIN && (sens_b || req_a)) || t1 == G_MAX))
          state_nx = A_YELLOW;
      B_GREEN:
        if (tick && ((t1 >= G_MIN && (sens_a || req_b)) || t1 == G_MAX))
          state_nx = B_YELLOW;
      A_YELLOW:
        if (tick && t1 == Y_T) state_nx = ALLRED_AB;
      B_YELLOW:
        if (tick && t1 == Y_T) state_nx = ALLRED_BA;
      ALLRED_AB:
        if (tick && t1 == AR_T) state_nx = night ? FLASH : B_GREEN;
      ALLRED_BA:
        if (tick && t1 == AR_T) state_nx = night ? FLASH : A_GREEN;
      FLASH:
        if (!night) state_nx = ALLRED_BA;
      default:
        state_nx = ALLRED_BA;
    endcase
  end

  // A press on the green-entry edge is served right away, not latched.
  always_comb begin
    req_a_nx = req_a | (btn_ped_a & ~walking_a);
    req_b_nx = req_b | (btn_ped_b & ~walking_b);
    timer_nx = timer;
    walk_nx  = walk;
    flash_nx = flash;
    if (state_nx != state) begin
      timer_nx = '0;
      walk_nx  = 1'b0;
      flash_nx = (state_nx == FLASH);
      if (state_nx == B_GREEN && (req_a || btn_ped_a)) begin
        walk_nx  = 1'b1;
        req_a_nx = 1'b0;
      end
      if (state_nx == A_GREEN && (req_b || btn_ped_b)) begin
        walk_nx  = 1'b1;
        req_b_nx = 1'b0;
      end
    end else if (tick) begin
      timer_nx = timer + 8'd1;
      if (state == FLASH) flash_nx = ~flash;
    end
  end

  always_comb begin
    light_a = 3'b100;
    light_b = 3'b100;
    unique case (state)
      A_GREEN:  light_a = 3'b001;
      A_YELLOW: light_a = 3'b010;
      B_GREEN:  light_b = 3'b001;
      B_YELLOW: light_b = 3'b010;
      FLASH: begin
        light_a = flash ? 3'b010 : 3'b000;
        light_b = flash ? 3'b010 : 3'b000;
      end
      default: ;
    endcase
  end

  assign ped_a    = ~walking_a;
  assign ped_b    = ~walking_b;
  assign req_pend = {req_b, req_a};
  assign phase    = state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: directed test-plan sequences with literal
// expectations plus randomized traffic checked against a tick-level model.
module tb_intersection_ctrl;

  localparam int GMIN = 10;
  localparam int GMAX = 30;
  localparam int YT   = 3;
  localparam int ART  = 2;
  localparam int WT   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       sens_a = 1'b0;
  logic       sens_b = 1'b0;
  logic       btn_ped_a = 1'b0;
  logic       btn_ped_b = 1'b0;
  logic       night = 1'b0;
  logic [2:0] light_a, light_b;
  logic       ped_a, ped_b;
  logic [1:0] req_pend;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  intersection_ctrl #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT),
    .ALLRED_T(ART), .WALK_T(WT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .sens_a(sens_a), .sens_b(sens_b),
    .btn_ped_a(btn_ped_a), .btn_ped_b(btn_ped_b),
    .night(night),
    .light_a(light_a), .light_b(light_b),
    .ped_a(ped_a), .ped_b(ped_b),
    .req_pend(req_pend), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase number, ticks spent in it, sticky requests.
  int m_ph;
  int m_el;
  bit m_ra, m_rb, m_walk, m_fl;
  bit m_valid = 0;

  function automatic int dur(input int ph);
    if (ph == 1 || ph == 4) return YT;
    return ART;
  endfunction

  always @(posedge clk) begin
    int  nph;
    bit  na, nb, wa, wb;
    if (rst) begin
      m_ph = 5; m_el = 0; m_ra = 0; m_rb = 0;
      m_walk = 0; m_fl = 0; m_valid = 1;
    end else if (m_valid) begin
      wa = (m_ph == 3) && m_walk && (m_el < WT);
      wb = (m_ph == 0) && m_walk && (m_el < WT);
      nph = m_ph;
      if (m_ph == 0) begin
        if (tick && ((m_el + 1 >= GMIN && (sens_b || m_ra)) ||
                     m_el + 1 == GMAX)) nph = 1;
      end else if (m_ph == 3) begin
        if (tick && ((m_el + 1 >= GMIN && (sens_a || m_rb)) ||
                     m_el + 1 == GMAX)) nph = 4;
      end else if (m_ph == 6) begin
        if (!night) nph = 5;
      end else if (tick && m_el + 1 == dur(m_ph)) begin
        if (m_ph == 1) nph = 2;
        else if (m_ph == 4) nph = 5;
        else if (night) nph = 6;
        else nph = (m_ph == 2) ? 3 : 0;
      end
      na = m_ra || (btn_ped_a && !wa);
      nb = m_rb || (btn_ped_b && !wb);
      if (nph != m_ph) begin
        m_el = 0;
        m_walk = 0;
        m_fl = (nph == 6);
        if (nph == 3 && (m_ra || btn_ped_a)) begin m_walk = 1; na = 0; end
        if (nph == 0 && (m_rb || btn_ped_b)) begin m_walk = 1; nb = 0; end
      end else if (tick) begin
        m_el++;
        if (m_ph == 6) m_fl = !m_fl;
      end
      m_ph = nph;
      m_ra = na;
      m_rb = nb;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    logic [2:0] ea, eb;
    logic       epa, epb;
    if (m_valid) begin
      ea = 3'b100; eb = 3'b100;
      case (m_ph)
        0: ea = 3'b001;
        1: ea = 3'b010;
        3: eb = 3'b001;
        4: eb = 3'b010;
        6: begin
          ea = m_fl ? 3'b010 : 3'b000;
          eb = ea;
        end
        default: ;
      endcase
      epa = !(m_ph == 3 && m_walk && m_el < WT);
      epb = !(m_ph == 0 && m_walk && m_el < WT);
      chk("mdl_light_a", 32'(light_a), 32'(ea));
      chk("mdl_light_b", 32'(light_b), 32'(eb));
      chk("mdl_ped_a", 32'(ped_a), 32'(epa));
      chk("mdl_ped_b", 32'(ped_b), 32'(epb));
      chk("mdl_req_pend", 32'(req_pend), 32'({m_rb, m_ra}));
      chk("mdl_phase", 32'(phase), 32'(m_ph));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_seq(input string name, input logic [2:0] la,
                         input logic [2:0] lb, input int n);
    for (int i = 0; i < n; i++) begin
      chk({name, "_a"}, 32'(light_a), 32'(la));
      chk({name, "_b"}, 32'(light_b), 32'(lb));
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    tick = 1'b1; sens_a = 1'b0; sens_b = 1'b0;
    btn_ped_a = 1'b0; btn_ped_b = 1'b0; night = 1'b0;
  endtask

  initial begin
    // Test 1: free run, no demand
    idle_inputs();
    do_reset();
    chk("t1_rst_req", 32'(req_pend), 32'h0);
    chk("t1_rst_peds", 32'({ped_a, ped_b}), 32'h3);
    chk("t1_rst_phase", 32'(phase), 32'd5);
    chk_seq("t1_ar0", 3'b100, 3'b100, 2);
    chk_seq("t1_ag", 3'b001, 3'b100, 30);
    chk_seq("t1_ay", 3'b010, 3'b100, 3);
    chk_seq("t1_ar1", 3'b100, 3'b100, 2);
    chk_seq("t1_bg", 3'b100, 3'b001, 30);

    // Test 2: sens_b from reset shortens A green to the minimum
    idle_inputs();
    sens_b = 1'b1;
    do_reset();
    chk_seq("t2_ar", 3'b100, 3'b100, 2);
    chk_seq("t2_ag", 3'b001, 3'b100, 10);
    chk_seq("t2_ay", 3'b010, 3'b100, 1);

    // Test 3: pedestrian request over road A
    idle_inputs();
    do_reset();
    chk_seq("t3_ar", 3'b100, 3'b100, 2);
    chk_seq("t3_ag0", 3'b001, 3'b100, 3);
    btn_ped_a = 1'b1;
    @(negedge clk);
    btn_ped_a = 1'b0;
    chk("t3_req", 32'(req_pend), 32'h1);
    chk_seq("t3_ag1", 3'b001, 3'b100, 6);
    chk_seq("t3_ay", 3'b010, 3'b100, 3);
    chk_seq("t3_ar1", 3'b100, 3'b100, 2);
    for (int i = 0; i < WT; i++) begin
      chk("t3_walk", 32'(ped_a), 32'h0);
      chk("t3_req_clr", 32'(req_pend), 32'h0);
      chk("t3_bg", 32'(light_b), 32'b001);
      @(negedge clk);
    end
    chk("t3_walk_end", 32'(ped_a), 32'h1);

    // Test 4: night mode entered via all-red, left via ALLRED_BA
    idle_inputs();
    do_reset();
    chk_seq("t4_ar", 3'b100, 3'b100, 2);
    night = 1'b1;
    chk_seq("t4_ag", 3'b001, 3'b100, 30);
    chk_seq("t4_ay", 3'b010, 3'b100, 3);
    chk_seq("t4_ar1", 3'b100, 3'b100, 2);
    for (int k = 0; k < 6; k++) begin
      chk("t4_fl_a", 32'(light_a), (k % 2 == 0) ? 32'b010 : 32'b000);
      chk("t4_fl_b", 32'(light_b), (k % 2 == 0) ? 32'b010 : 32'b000);
      chk("t4_fl_ped", 32'({ped_a, ped_b}), 32'h3);
      @(negedge clk);
    end
    night = 1'b0;
    @(negedge clk);
    chk_seq("t4_ar2", 3'b100, 3'b100, 2);
    chk_seq("t4_ag2", 3'b001, 3'b100, 1);

    // Test 5: reset during B_YELLOW with a pending B request
    idle_inputs();
    sens_a = 1'b1;
    sens_b = 1'b1;
    do_reset();
    chk_seq("t5_ar", 3'b100, 3'b100, 2);
    chk_seq("t5_ag", 3'b001, 3'b100, 10);
    chk_seq("t5_ay", 3'b010, 3'b100, 3);
    chk_seq("t5_ar1", 3'b100, 3'b100, 2);
    chk_seq("t5_bg", 3'b100, 3'b001, 10);
    btn_ped_b = 1'b1;
    @(negedge clk);
    btn_ped_b = 1'b0;
    chk("t5_by", 32'(light_b), 32'b010);
    chk("t5_req", 32'(req_pend), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_la", 32'(light_a), 32'b100);
    chk("t5_lb", 32'(light_b), 32'b100);
    chk("t5_peds", 32'({ped_a, ped_b}), 32'h3);
    chk("t5_req0", 32'(req_pend), 32'h0);
    chk("t5_phase", 32'(phase), 32'd5);

    // Test 6: tick gating freezes A green mid-phase
    idle_inputs();
    do_reset();
    chk_seq("t6_ar", 3'b100, 3'b100, 2);
    chk_seq("t6_ag0", 3'b001, 3'b100, 5);
    tick = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk("t6_hold_a", 32'(light_a), 32'b001);
      chk("t6_hold_ph", 32'(phase), 32'd0);
      @(negedge clk);
    end
    tick = 1'b1;
    chk_seq("t6_ag1", 3'b001, 3'b100, 25);
    chk_seq("t6_ay", 3'b010, 3'b100, 1);

    // Randomized traffic against the model
    idle_inputs();
    for (int i = 0; i < 6000; i++) begin
      tick      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) sens_a = ~sens_a;
      if ($urandom_range(0, 7) == 0) sens_b = ~sens_b;
      btn_ped_a = ($urandom_range(0, 15) == 0);
      btn_ped_b = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) night = ~night;
      rst       = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
